// File: rtl/bcd_counter_n_pkg.sv
// Shared types and constants for the cascaded BCD up/down counter.
package bcd_counter_n_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam int         MIN_DIGITS = 1;
  localparam int         MAX_DIGITS = 8;

endpackage

// File: rtl/bcd_counter_n_digit_ud.sv
// One BCD digit of the cascade: computes its next value and ripples the step on.
module bcd_digit_ud
  import bcd_counter_n_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_step,
  input  logic       i_up,
  output bcd_digit_t o_next,
  output logic       o_limit,
  output logic       o_step
);

  // The limit is the digit that rolls over in the current direction.
  assign o_limit = i_up ? (i_digit >= BCD_MAX) : (i_digit == 4'd0);
  assign o_step  = i_step & o_limit;

  always_comb begin
    o_next = i_digit;
    if (i_step) begin
      if (i_up) o_next = (i_digit >= BCD_MAX) ? 4'd0 : i_digit + 4'd1;
      else      o_next = (i_digit == 4'd0) ? BCD_MAX : i_digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with clear, validated load and wrap or saturate limits.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry_out,
  output logic                    tc,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;

  logic [1:0]            r_rst_sync;
  logic                  w_run;
  logic [W-1:0]          r_count;
  logic                  r_carry;
  logic                  r_load_err;
  logic [W-1:0]          w_next;
  logic [NUM_DIGITS-1:0] w_limit;
  logic [NUM_DIGITS:0]   w_step;
  logic                  w_load_ok;
  logic [W-1:0]          w_count_d;
  logic                  w_carry_d;
  logic                  w_err_d;

  // Reset asserts asynchronously; release is retimed so no step happens on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_run = r_rst_sync[1];

  assign w_step[0] = 1'b1;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_ud u_digit (
      .i_digit (r_count[4*k +: 4]),
      .i_step  (w_step[k]),
      .i_up    (up),
      .o_next  (w_next[4*k +: 4]),
      .o_limit (w_limit[k]),
      .o_step  (w_step[k+1])
    );
  end

  always_comb begin
    w_load_ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (load_val[4*k +: 4] > BCD_MAX) w_load_ok = 1'b0;
    end
  end

  // A step out of the top digit means the whole count sits at its limit.
  always_comb begin
    w_count_d = r_count;
    w_carry_d = 1'b0;
    w_err_d   = 1'b0;
    if (w_run) begin
      if (clr) begin
        w_count_d = '0;
      end else if (load) begin
        if (w_load_ok) w_count_d = load_val;
        else           w_err_d   = 1'b1;
      end else if (en) begin
        if (w_step[NUM_DIGITS]) begin
          w_carry_d = 1'b1;
          if (WRAP) w_count_d = w_next;
        end else begin
          w_count_d = w_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_carry    <= w_carry_d;
      r_load_err <= w_err_d;
    end
  end

  assign count     = r_count;
  assign carry_out = r_carry;
  assign load_err  = r_load_err;
  assign tc        = &w_limit;

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at the count limits; 0 = saturate at the count limits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable, one step per cycle while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 clr  input  1  synchronous clear to zero.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  4*NUM_DIGITS  BCD load value; digit 0 is in bits [3:0].
REQ-010 count  output  4*NUM_DIGITS  registered BCD count; digit 0 is in bits [3:0].
REQ-011 carry_out  output  1  registered one-cycle pulse on overflow (up) or underflow (down).
REQ-012 tc  output  1  combinational terminal count: count is all-9s when up=1, or all-0s when up=0.
REQ-013 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-014 The block SHALL apply the control inputs with priority clr > load > en; when none is high, it SHALL hold count.
REQ-015 When clr is high, count SHALL become 0 on the next edge, and carry_out and load_err SHALL be low.
REQ-016 The block SHALL reject a load if any load_val digit exceeds 9: count holds and load_err pulses high for one cycle.
REQ-017 The block SHALL accept a load only if every load_val digit is 0..9: count = load_val on the next edge and load_err is low.
REQ-018 Each count step SHALL have a latency of one edge.
- Up: digit k increments when every lower digit is 9; a digit at 9 becomes 0.
- Down: digit k decrements when every lower digit is 0; a digit at 0 becomes 9.
REQ-019 Overflow (up at all-9s), WRAP=1: count SHALL become 0, with carry_out high in the same cycle the new count appears.
REQ-020 Underflow (down at all-0s), WRAP=1: count SHALL become all-9s, with carry_out high in the same cycle.
REQ-021 WRAP=0: at a limit with en high, count SHALL hold, and carry_out SHALL pulse once per attempted step beyond the limit.
REQ-022 carry_out SHALL be low in every cycle not covered by REQ-019 to REQ-021.
REQ-023 A change of up between cycles SHALL take effect on the next step, with no dead cycle.
REQ-024 count SHALL never hold a non-BCD digit (value 10..15), under any input sequence.
REQ-025 tc SHALL depend only on count and up, with no clock-edge dependency.

Reset
REQ-026 While rst_n is low, count = 0, carry_out = 0 and load_err = 0, regardless of clk.
REQ-027 Deassertion of rst_n SHALL be synchronised internally.
- The first count step occurs no earlier than the second rising edge after deassertion.
REQ-028 Reset asserted mid-count SHALL clear the state immediately.
- No carry_out pulse is emitted for the interrupted step.

Structure
REQ-029 A shared package SHALL hold the digit type (4-bit BCD), the BCD_MAX constant (9) and the NUM_DIGITS legal range.
REQ-030 The block SHALL instantiate one sub-module per digit, bcd_digit_ud.
- Ports: digit value, step-in and up.
- Outputs: next digit, limit flag (9 up / 0 down) and step-out.
- Cascading uses a generate loop.
REQ-031 The top level SHALL contain only the following:
- the clr/load/en priority logic;
- the load validation;
- the wrap/saturate selection;
- the output registers.

Verification
REQ-032 The bench SHALL cover at least these directed scenarios, with NUM_DIGITS=4 and WRAP=1 unless stated:
- Reset, then en=1 up=1 for 10 cycles -> count 0000..0010, carry_out never high.
- Load 9998, up=1 en=1 -> next edges give 9999 (tc=1), then 0000 with carry_out high for exactly one cycle.
- Load 0001, up=0 en=1 -> 0000 (tc=1), then 9999 with carry_out pulse; then up=1 -> 0000 with carry_out pulse.
- WRAP=0: load 9999, up=1 en=1 for 3 cycles -> count stays 9999, carry_out high each cycle; then up=0 -> 9998.
- Load 0x12A4 -> load_err pulses, count unchanged; clr and load together -> count 0000.
- rst_n low mid-count at 0457 between edges -> count 0000 immediately; after release, the first step occurs no earlier than the second edge.
